cla_adder_16: RTL and testbench

//   16-bit two-level carry-lookahead adder with registered outputs.
//   - Level 1: four 4-bit CLA groups.
//   - Level 2: one lookahead unit computing the inter-group carries.
//   - Exports group propagate/generate so the block can be cascaded into wider adders.
//   - Serves as the ALU add/sub datapath core of the pipelined CPU.

---
 rtl/cla_adder_16_if.sv | 22 ++
 rtl/cla_adder_16.sv | 107 ++++++++++
 tb/tb_cla_adder_16.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cla_adder_16_if.sv
// Operand/result bundle for the 16-bit carry-lookahead adder.
// master: the client that supplies operands and reads results.
// slave: the adder itself.
interface cla_adder_16_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] R;
  logic        CG;
  logic        PG;
  logic        GG;

  modport master (
    output A, B, Cin,
    input  R, CG, PG, GG
  );

  modport slave (
    input  A, B, Cin,
    output R, CG, PG, GG
  );
endinterface

// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder with registered outputs.
// Level 1 is four 4-bit lookahead groups. Level 2 is one lookahead unit
// that produces the carry into each group from the group P/G terms.
// Group propagate/generate are exported so the block can be cascaded
// into wider adders. The latency is one cycle, with no enable.
module cla_adder_16 (
  input  logic          clk,
  input  logic          rst_n,
  cla_adder_16_if.slave bus
);

  // Group propagate: every bit in the group passes a carry through.
  function automatic logic grp_prop(input logic [3:0] p);
    return &p;
  endfunction

  // Group generate: the group produces a carry on its own, ignoring its carry-in.
  function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
    return g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carries into the four bits of one group, fully expanded (no ripple).
  function automatic logic [3:0] grp_carries(input logic [3:0] p,
                                             input logic [3:0] g,
                                             input logic       c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic [15:0] p;
  logic [15:0] g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [4:0]  gc;
  logic [15:0] c;

  logic [15:0] r_d;
  logic        cg_d;
  logic        pg_d;
  logic        gg_d;

  logic [15:0] r_q;
  logic        cg_q;
  logic        pg_q;
  logic        gg_q;

  // Two-level lookahead: bit P/G, then group P/G, then group carries, then the sum.
  always_comb begin
    p     = bus.A ^ bus.B;
    g     = bus.A & bus.B;
    grp_p = '0;
    grp_g = '0;
    c     = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = grp_prop(p[4*k +: 4]);
      grp_g[k] = grp_gen(p[4*k +: 4], g[4*k +: 4]);
    end

    gc[0] = bus.Cin;
    gc[1] = grp_g[0] | (grp_p[0] & bus.Cin);
    gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & bus.Cin);
    gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & bus.Cin);
    gc[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & bus.Cin);

    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = grp_carries(p[4*k +: 4], g[4*k +: 4], gc[k]);
    end

    r_d  = p ^ c;
    cg_d = gc[4];
    pg_d = &grp_p;
    // GG excludes Cin, so cascaded adders can combine it with their own carry.
    gg_d = grp_gen(grp_p, grp_g);
  end

  // Output register; reset clears all results immediately and discards any pending sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= 16'h0000;
      cg_q <= 1'b0;
      pg_q <= 1'b0;
      gg_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      cg_q <= cg_d;
      pg_q <= pg_d;
      gg_q <= gg_d;
    end
  end

  assign bus.R  = r_q;
  assign bus.CG = cg_q;
  assign bus.PG = pg_q;
  assign bus.GG = gg_q;

endmodule

// File: tb/tb_cla_adder_16.sv
// Testbench for cla_adder_16: directed vectors, random back-to-back
// vectors against an arithmetic reference, and asynchronous reset.
module tb_cla_adder_16;

  logic clk;
  logic rst_n;
  int   n_asrt;
  int   n_fail;

  cla_adder_16_if bus ();

  cla_adder_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Compare all outputs against the given expected values.
  task automatic check_out(input string tag, input logic [15:0] er,
                           input logic ecg, input logic epg, input logic egg);
    n_asrt++;
    assert (bus.R === er) else begin
      n_fail++;
      $error("FAIL %s R: observed %h expected %h", tag, bus.R, er);
    end
    n_asrt++;
    assert (bus.CG === ecg) else begin
      n_fail++;
      $error("FAIL %s CG: observed %b expected %b", tag, bus.CG, ecg);
    end
    n_asrt++;
    assert (bus.PG === epg) else begin
      n_fail++;
      $error("FAIL %s PG: observed %b expected %b", tag, bus.PG, epg);
    end
    n_asrt++;
    assert (bus.GG === egg) else begin
      n_fail++;
      $error("FAIL %s GG: observed %b expected %b", tag, bus.GG, egg);
    end
  endtask

  // Drive one operand set, then check the result one edge later against arithmetic.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    logic [16:0] full;
    logic [16:0] nocin;
    logic        epg;
    @(negedge clk);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
    full  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    nocin = {1'b0, a} + {1'b0, b};
    epg   = ((a ^ b) == 16'hFFFF);
    @(posedge clk);
    #1;
    check_out(tag, full[15:0], full[16], epg, nocin[16]);
    n_asrt++;
    assert (bus.CG === (bus.GG | (bus.PG & cin))) else begin
      n_fail++;
      $error("FAIL %s identity: observed CG %b expected %b", tag, bus.CG,
             bus.GG | (bus.PG & cin));
    end
  endtask

  initial begin
    n_asrt  = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.A   = 16'h1234;
    bus.B   = 16'hFFFF;
    bus.Cin = 1'b1;

    // Reset holds outputs at zero even while clocking with live operands.
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    apply("add_2_3",     16'd2,     16'd3,     1'b0);
    check_out("add_2_3_k", 16'd5, 1'b0, 1'b0, 1'b0);
    apply("add_9_5",     16'd9,     16'd5,     1'b0);
    check_out("add_9_5_k", 16'd14, 1'b0, 1'b0, 1'b0);
    apply("fullprop",    16'hFFDC,  16'h0023,  1'b0);
    check_out("fullprop_k", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    apply("fullprop_c",  16'hFFDC,  16'h0023,  1'b1);
    check_out("fullprop_c_k", 16'h0000, 1'b1, 1'b1, 1'b0);
    apply("gen",         16'hFFDC,  16'h01F4,  1'b0);
    check_out("gen_k", 16'h01D0, 1'b1, 1'b0, 1'b1);
    apply("ffff_0_1",    16'hFFFF,  16'h0000,  1'b1);
    apply("ffff_ffff_1", 16'hFFFF,  16'hFFFF,  1'b1);
    apply("msb_wrap",    16'h8000,  16'h8000,  1'b0);
    apply("zero",        16'h0000,  16'h0000,  1'b0);
    apply("or_not_xor",  16'hFFFF,  16'hFFFF,  1'b0);

    // Random back-to-back vectors.
    for (int i = 0; i < 200; i++) begin
      apply("random", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // Mid-stream asynchronous reset clears outputs without waiting for a clock edge.
    apply("pre_reset", 16'hFFDC, 16'h01F4, 1'b0);
    @(negedge clk);
    bus.A   = 16'h7FFF;
    bus.B   = 16'h7FFF;
    bus.Cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_reset", 16'h1111, 16'h2222, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply("random2", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
